mwrite: RTL and testbench

//  Memory-write stage directly downstream of the memory-read stage. Latches that stage's register

---
 rtl/mwrite_pkg.sv | 13 +
 rtl/mwrite.sv | 116 +++++++++++
 tb/tb_mwrite.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mwrite_pkg.sv
// mwrite_pkg: shared encodings for the memory-write stage.
// FSM states and bus strobe width.
package mwrite_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int STRB_W = 4;

endpackage

// File: rtl/mwrite.sv
// mwrite: memory-write stage. Issues one bus store per captured
// request and holds the pipeline until its response or timeout.
module mwrite
  import mwrite_pkg::*;
#(
  parameter int RESP_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic [4:0]        MEMR_REG_W_RD,
  input  logic [31:0]       MEMR_REG_W_DATA,
  input  logic              MEMR_MEM_W_VALID,
  input  logic [31:0]       MEMR_MEM_W_ADDR,
  input  logic [STRB_W-1:0] MEMR_MEM_W_STRB,
  input  logic [31:0]       MEMR_MEM_W_DATA,
  output logic              MEM_W_VALID,
  output logic [31:0]       MEM_W_ADDR,
  output logic [STRB_W-1:0] MEM_W_STRB,
  output logic [31:0]       MEM_W_DATA,
  input  logic              MEM_W_READY,
  input  logic              MEM_W_RESP_VALID,
  input  logic              MEM_W_RESP_ERR,
  output logic [4:0]        MEMW_REG_W_RD,
  output logic [31:0]       MEMW_REG_W_DATA,
  output logic              MEMW_STALL_REQ,
  output logic              MEMW_ERR,
  output logic [31:0]       MEMW_ERR_ADDR
);

  localparam int CW =
    (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
  localparam bit TMO_EN = RESP_TIMEOUT > 0;
  localparam logic [CW-1:0] TMO_LAST =
    CW'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

  state_t            state;
  logic [4:0]        rd_q;
  logic [31:0]       wb_q;
  logic              vld_q;
  logic [31:0]       addr_q;
  logic [STRB_W-1:0] strb_q;
  logic [31:0]       data_q;
  logic              done;
  logic [CW-1:0]     cnt;
  logic              pending;
  logic              cap;

  assign pending = vld_q & (|strb_q) & ~done;
  assign cap     = ~(STALL | pending);

  assign MEMW_STALL_REQ  = pending;
  assign MEM_W_VALID     = (state == S_REQ);
  assign MEM_W_ADDR      = addr_q;
  assign MEM_W_STRB      = strb_q;
  assign MEM_W_DATA      = data_q;
  assign MEMW_REG_W_RD   = rd_q;
  assign MEMW_REG_W_DATA = wb_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= S_IDLE;
      rd_q          <= '0;
      wb_q          <= '0;
      vld_q         <= 1'b0;
      addr_q        <= '0;
      strb_q        <= '0;
      data_q        <= '0;
      done          <= 1'b0;
      cnt           <= '0;
      MEMW_ERR      <= 1'b0;
      MEMW_ERR_ADDR <= '0;
    end else begin
      MEMW_ERR <= 1'b0;
      if (cap) begin
        rd_q   <= MEMR_REG_W_RD;
        wb_q   <= MEMR_REG_W_DATA;
        vld_q  <= MEMR_MEM_W_VALID;
        addr_q <= MEMR_MEM_W_ADDR;
        strb_q <= MEMR_MEM_W_STRB;
        data_q <= MEMR_MEM_W_DATA;
        done   <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (pending) state <= S_REQ;
        end
        S_REQ: begin
          if (MEM_W_READY) begin
            state <= S_RESP;
            cnt   <= '0;
          end
        end
        S_RESP: begin
          if (MEM_W_RESP_VALID) begin
            state <= S_IDLE;
            done  <= 1'b1;
            if (MEM_W_RESP_ERR) begin
              MEMW_ERR      <= 1'b1;
              MEMW_ERR_ADDR <= addr_q;
            end
          end else if (TMO_EN && cnt == TMO_LAST) begin
            state         <= S_IDLE;
            done          <= 1'b1;
            MEMW_ERR      <= 1'b1;
            MEMW_ERR_ADDR <= addr_q;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mwrite.sv
// tb_mwrite: scenario tasks plus bus and error scoreboards
// for the memory-write stage.
module tb_mwrite;
  import mwrite_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic [4:0]  MEMR_REG_W_RD;
  logic [31:0] MEMR_REG_W_DATA;
  logic        MEMR_MEM_W_VALID;
  logic [31:0] MEMR_MEM_W_ADDR;
  logic [3:0]  MEMR_MEM_W_STRB;
  logic [31:0] MEMR_MEM_W_DATA;
  logic        MEM_W_VALID;
  logic [31:0] MEM_W_ADDR;
  logic [3:0]  MEM_W_STRB;
  logic [31:0] MEM_W_DATA;
  logic        MEM_W_READY;
  logic        MEM_W_RESP_VALID;
  logic        MEM_W_RESP_ERR;
  logic [4:0]  MEMW_REG_W_RD;
  logic [31:0] MEMW_REG_W_DATA;
  logic        MEMW_STALL_REQ;
  logic        MEMW_ERR;
  logic [31:0] MEMW_ERR_ADDR;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] err_q[$];
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;

  mwrite #(.RESP_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .MEMR_REG_W_RD(MEMR_REG_W_RD),
    .MEMR_REG_W_DATA(MEMR_REG_W_DATA),
    .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID),
    .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
    .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB),
    .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA),
    .MEM_W_VALID(MEM_W_VALID),
    .MEM_W_ADDR(MEM_W_ADDR),
    .MEM_W_STRB(MEM_W_STRB),
    .MEM_W_DATA(MEM_W_DATA),
    .MEM_W_READY(MEM_W_READY),
    .MEM_W_RESP_VALID(MEM_W_RESP_VALID),
    .MEM_W_RESP_ERR(MEM_W_RESP_ERR),
    .MEMW_REG_W_RD(MEMW_REG_W_RD),
    .MEMW_REG_W_DATA(MEMW_REG_W_DATA),
    .MEMW_STALL_REQ(MEMW_STALL_REQ),
    .MEMW_ERR(MEMW_ERR),
    .MEMW_ERR_ADDR(MEMW_ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  // Bus handshake scoreboard.
  always @(negedge CLK) begin
    if (RST === 1'b1 && MEM_W_VALID && MEM_W_READY) begin
      bus_t e;
      hs_cnt++;
      checks++;
      if (bus_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexp got %h/%h/%h required none",
                 MEM_W_ADDR, MEM_W_STRB, MEM_W_DATA);
      end else begin
        e = bus_q.pop_front();
        if ({MEM_W_ADDR, MEM_W_STRB, MEM_W_DATA} !== e) begin
          errors++;
          $display("FAIL bus_req got %h/%h/%h required %h/%h/%h",
                   MEM_W_ADDR, MEM_W_STRB, MEM_W_DATA,
                   e.addr, e.strb, e.data);
        end
      end
    end
  end

  // Error scoreboard.
  always @(negedge CLK) begin
    if (RST === 1'b1 && MEMW_ERR) begin
      logic [31:0] ea;
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL err_unexp got addr %h required no error",
                 MEMW_ERR_ADDR);
      end else begin
        ea = err_q.pop_front();
        if (MEMW_ERR_ADDR !== ea) begin
          errors++;
          $display("FAIL err_addr got %h required %h",
                   MEMW_ERR_ADDR, ea);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    MEMR_REG_W_RD    = '0;
    MEMR_REG_W_DATA  = '0;
    MEMR_MEM_W_VALID = 1'b0;
    MEMR_MEM_W_ADDR  = '0;
    MEMR_MEM_W_STRB  = '0;
    MEMR_MEM_W_DATA  = '0;
  endtask

  task automatic drive(input logic [4:0] rd,
                       input logic [31:0] wb,
                       input logic v,
                       input logic [31:0] a,
                       input logic [3:0] s,
                       input logic [31:0] d);
    MEMR_REG_W_RD    = rd;
    MEMR_REG_W_DATA  = wb;
    MEMR_MEM_W_VALID = v;
    MEMR_MEM_W_ADDR  = a;
    MEMR_MEM_W_STRB  = s;
    MEMR_MEM_W_DATA  = d;
    if (v && s != 0) bus_q.push_back({a, s, d});
  endtask

  task automatic test_reset();
    RST = 1'b0; STALL = 1'b1;
    MEMR_REG_W_RD = '1; MEMR_REG_W_DATA = '1;
    MEMR_MEM_W_VALID = 1'b1; MEMR_MEM_W_ADDR = '1;
    MEMR_MEM_W_STRB = '1; MEMR_MEM_W_DATA = '1;
    MEM_W_READY = 1'b1; MEM_W_RESP_VALID = 1'b1;
    MEM_W_RESP_ERR = 1'b1;
    tick(); tick();
    checks++;
    if ({MEM_W_VALID, MEM_W_ADDR, MEM_W_STRB, MEM_W_DATA,
         MEMW_REG_W_RD, MEMW_REG_W_DATA, MEMW_STALL_REQ,
         MEMW_ERR, MEMW_ERR_ADDR} !== '0) begin
      errors++;
      $display("FAIL reset_outs got v%b a%h rd%h st%b e%b ea%h required 0",
               MEM_W_VALID, MEM_W_ADDR, MEMW_REG_W_RD,
               MEMW_STALL_REQ, MEMW_ERR, MEMW_ERR_ADDR);
    end
    checks++;
    if (dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d required 0", dut.state);
    end
    idle_in(); STALL = 1'b0;
    MEM_W_READY = 1'b0; MEM_W_RESP_VALID = 1'b0;
    MEM_W_RESP_ERR = 1'b0;
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_store();
    drive(5'd3, 32'hA5, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
    tick();
    idle_in();
    checks++;
    if (MEMW_STALL_REQ !== 1'b1 || MEM_W_VALID !== 1'b0) begin
      errors++;
      $display("FAIL store_cap got st%b v%b required st1 v0",
               MEMW_STALL_REQ, MEM_W_VALID);
    end
    MEM_W_READY = 1'b1;
    tick();
    checks++;
    if (MEM_W_VALID !== 1'b1 || MEMW_STALL_REQ !== 1'b1) begin
      errors++;
      $display("FAIL store_req got v%b st%b required v1 st1",
               MEM_W_VALID, MEMW_STALL_REQ);
    end
    tick();
    MEM_W_READY = 1'b0;
    checks++;
    if (MEM_W_VALID !== 1'b0 || MEMW_STALL_REQ !== 1'b1) begin
      errors++;
      $display("FAIL store_resp1 got v%b st%b required v0 st1",
               MEM_W_VALID, MEMW_STALL_REQ);
    end
    tick();
    checks++;
    if (MEMW_STALL_REQ !== 1'b1) begin
      errors++;
      $display("FAIL store_resp2 got st%b required 1",
               MEMW_STALL_REQ);
    end
    MEM_W_RESP_VALID = 1'b1;
    tick();
    MEM_W_RESP_VALID = 1'b0;
    checks++;
    if (MEMW_STALL_REQ !== 1'b0 || MEMW_ERR !== 1'b0 ||
        MEMW_REG_W_RD !== 5'd3) begin
      errors++;
      $display("FAIL store_done got st%b e%b rd%0d required st0 e0 rd3",
               MEMW_STALL_REQ, MEMW_ERR, MEMW_REG_W_RD);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(5'd4, 32'h44, 1'b1, 32'h2000, 4'h3, 32'h12345678);
    tick();
    tick();
    drive(5'd9, 32'h99, 1'b1, 32'h9990, 4'hF, 32'h0BADF00D);
    void'(bus_q.pop_back());
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (MEM_W_VALID !== 1'b1 || MEM_W_ADDR !== 32'h2000 ||
          MEM_W_DATA !== 32'h12345678 ||
          MEMW_REG_W_RD !== 5'd4) begin
        errors++;
        $display("FAIL bp_hold%0d got v%b a%h d%h rd%0d required v1 a2000 d12345678 rd4",
                 i, MEM_W_VALID, MEM_W_ADDR, MEM_W_DATA,
                 MEMW_REG_W_RD);
      end
    end
    idle_in();
    MEM_W_READY = 1'b1;
    tick();
    MEM_W_READY = 1'b0;
    MEM_W_RESP_VALID = 1'b1;
    tick();
    MEM_W_RESP_VALID = 1'b0;
    checks++;
    if (MEMW_STALL_REQ !== 1'b0) begin
      errors++;
      $display("FAIL bp_done got st%b required 0", MEMW_STALL_REQ);
    end
    tick();
  endtask

  task automatic test_bus_error();
    drive(5'd0, 32'h0, 1'b1, 32'h1000, 4'h1, 32'h000000EE);
    err_q.push_back(32'h1000);
    tick();
    idle_in();
    MEM_W_READY = 1'b1;
    tick();
    tick();
    MEM_W_READY = 1'b0;
    MEM_W_RESP_VALID = 1'b1;
    MEM_W_RESP_ERR = 1'b1;
    tick();
    MEM_W_RESP_VALID = 1'b0;
    MEM_W_RESP_ERR = 1'b0;
    checks++;
    if (MEMW_ERR !== 1'b1 || MEMW_ERR_ADDR !== 32'h1000 ||
        MEMW_STALL_REQ !== 1'b0) begin
      errors++;
      $display("FAIL berr_pulse got e%b ea%h st%b required e1 ea1000 st0",
               MEMW_ERR, MEMW_ERR_ADDR, MEMW_STALL_REQ);
    end
    tick();
    checks++;
    if (MEMW_ERR !== 1'b0 || MEMW_ERR_ADDR !== 32'h1000) begin
      errors++;
      $display("FAIL berr_after got e%b ea%h required e0 ea1000",
               MEMW_ERR, MEMW_ERR_ADDR);
    end
  endtask

  task automatic test_timeout();
    drive(5'd0, 32'h0, 1'b1, 32'h3000, 4'hC, 32'hCAFE0000);
    err_q.push_back(32'h3000);
    tick();
    idle_in();
    MEM_W_READY = 1'b1;
    tick();
    tick();
    MEM_W_READY = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (MEMW_STALL_REQ !== 1'b1 || MEMW_ERR !== 1'b0) begin
        errors++;
        $display("FAIL tmo_wait%0d got st%b e%b required st1 e0",
                 i, MEMW_STALL_REQ, MEMW_ERR);
      end
    end
    tick();
    checks++;
    if (MEMW_ERR !== 1'b1 || MEMW_STALL_REQ !== 1'b0 ||
        MEMW_ERR_ADDR !== 32'h3000) begin
      errors++;
      $display("FAIL tmo_fire got e%b st%b ea%h required e1 st0 ea3000",
               MEMW_ERR, MEMW_STALL_REQ, MEMW_ERR_ADDR);
    end
    tick();
  endtask

  task automatic test_no_store();
    drive(5'd5, 32'h55, 1'b1, 32'h6000, 4'h0, 32'h11);
    tick();
    idle_in();
    checks++;
    if (MEMW_REG_W_RD !== 5'd5 || MEMW_REG_W_DATA !== 32'h55 ||
        MEMW_STALL_REQ !== 1'b0) begin
      errors++;
      $display("FAIL nostore_wb got rd%0d d%h st%b required rd5 d55 st0",
               MEMW_REG_W_RD, MEMW_REG_W_DATA, MEMW_STALL_REQ);
    end
    tick();
    checks++;
    if (MEM_W_VALID !== 1'b0 || MEMW_STALL_REQ !== 1'b0 ||
        MEMW_REG_W_RD !== 5'd0) begin
      errors++;
      $display("FAIL nostore_bus got v%b st%b rd%0d required v0 st0 rd0",
               MEM_W_VALID, MEMW_STALL_REQ, MEMW_REG_W_RD);
    end
  endtask

  task automatic test_mid_reset();
    drive(5'd6, 32'h66, 1'b1, 32'h4000, 4'hF, 32'h44444444);
    tick();
    idle_in();
    MEM_W_READY = 1'b1;
    tick();
    tick();
    MEM_W_READY = 1'b0;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    checks++;
    if (MEM_W_VALID !== 1'b0 || MEMW_STALL_REQ !== 1'b0 ||
        dut.state !== S_IDLE || MEM_W_ADDR !== 32'h0) begin
      errors++;
      $display("FAIL midrst got v%b st%b s%0d a%h required v0 st0 s0 a0",
               MEM_W_VALID, MEMW_STALL_REQ, dut.state, MEM_W_ADDR);
    end
    MEM_W_RESP_VALID = 1'b1;
    MEM_W_RESP_ERR = 1'b1;
    tick();
    MEM_W_RESP_VALID = 1'b0;
    MEM_W_RESP_ERR = 1'b0;
    checks++;
    if (MEMW_ERR !== 1'b0 || MEM_W_VALID !== 1'b0 ||
        MEMW_STALL_REQ !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late got e%b v%b st%b required 0 0 0",
               MEMW_ERR, MEM_W_VALID, MEMW_STALL_REQ);
    end
    tick();
  endtask

  task automatic test_ext_stall();
    drive(5'd7, 32'h77, 1'b1, 32'h5000, 4'h8, 32'h5A000000);
    tick();
    STALL = 1'b1;
    drive(5'd9, 32'h99, 1'b1, 32'h5100, 4'hF, 32'h1);
    void'(bus_q.pop_back());
    tick();
    checks++;
    if (MEM_W_VALID !== 1'b1) begin
      errors++;
      $display("FAIL xstall_req got v%b required 1", MEM_W_VALID);
    end
    MEM_W_READY = 1'b1;
    tick();
    MEM_W_READY = 1'b0;
    MEM_W_RESP_VALID = 1'b1;
    tick();
    MEM_W_RESP_VALID = 1'b0;
    checks++;
    if (MEMW_STALL_REQ !== 1'b0 || dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL xstall_done got st%b s%0d required st0 s0",
               MEMW_STALL_REQ, dut.state);
    end
    tick();
    checks++;
    if (MEMW_REG_W_RD !== 5'd7 || MEM_W_ADDR !== 32'h5000 ||
        MEM_W_VALID !== 1'b0) begin
      errors++;
      $display("FAIL xstall_hold got rd%0d a%h v%b required rd7 a5000 v0",
               MEMW_REG_W_RD, MEM_W_ADDR, MEM_W_VALID);
    end
    idle_in();
    STALL = 1'b0;
    tick();
    checks++;
    if (MEMW_REG_W_RD !== 5'd0) begin
      errors++;
      $display("FAIL xstall_rel got rd%0d required 0", MEMW_REG_W_RD);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = hs_cnt;
    MEM_W_READY = 1'b1;
    MEM_W_RESP_VALID = 1'b1;
    drive(5'd1, 32'h1, 1'b1, 32'h7000, 4'hF, 32'hAAAA0001);
    tick();
    drive(5'd2, 32'h2, 1'b1, 32'h7004, 4'h6, 32'h00BBBB00);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_cnt - base >= 2) idle_in();
    end
    MEM_W_READY = 1'b0;
    MEM_W_RESP_VALID = 1'b0;
    checks++;
    if (hs_cnt - base != 2 || MEMW_STALL_REQ !== 1'b0) begin
      errors++;
      $display("FAIL b2b got hs%0d st%b required hs2 st0",
               hs_cnt - base, MEMW_STALL_REQ);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_backpressure();
    test_bus_error();
    test_timeout();
    test_no_store();
    test_mid_reset();
    test_ext_stall();
    test_back_to_back();
    tick();
    checks++;
    if (bus_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got bus%0d err%0d required 0 0",
               bus_q.size(), err_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
